// File: rtl/alu_exec.sv
// alu_exec: single-issue ALU execute stage with a valid/ready request side and a
// valid/ready result side. Each request runs to completion before another is accepted.
// Shifts are computed one bit per cycle by default. Define ALU_BARREL_SHIFT_EN to compute
// shifts in a single cycle instead. Results are bit-identical in both builds.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o    request handshake; ready_o is high only when idle
//   alucontrol_i         5-bit operation code
//   operand_a_i/_b_i     source operands, captured when the request is accepted
//   pc_i                 program counter, used by the link (pc+4) operation
//   valid_o / ready_i    result handshake
//   result_o             result; zero whenever valid_o is low
//   branch_taken_o       redirect flag; zero whenever valid_o is low
module alu_exec (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  alucontrol_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        branch_taken_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [31:0] result_q;
  logic        taken_q;
  logic        valid_q;

  logic [4:0]  shamt;
  logic        is_shift;
  logic [31:0] comb_result;
  logic        comb_taken;

  assign shamt    = operand_b_i[4:0];
  assign is_shift = (alucontrol_i == 5'b00001) || (alucontrol_i == 5'b00101) ||
                    (alucontrol_i == 5'b01101);

`ifndef ALU_BARREL_SHIFT_EN
  logic [31:0] sh_q;
  logic [4:0]  cnt_q;
  logic        right_q;
  logic        arith_q;
  logic [31:0] sh_step;

  // One bit of shift per cycle; an arithmetic right shift replicates the sign bit.
  always_comb begin
    sh_step = right_q ? {arith_q & sh_q[31], sh_q[31:1]} : {sh_q[30:0], 1'b0};
  end
`endif

  // Single-cycle result for everything that does not go through the iterative shifter.
  always_comb begin
    comb_result = '0;
    comb_taken  = 1'b0;
    case (alucontrol_i)
      5'b00000: comb_result = operand_a_i + operand_b_i;
      5'b01000: comb_result = operand_a_i - operand_b_i;
      5'b00010: comb_result = {31'b0, $signed(operand_a_i) < $signed(operand_b_i)};
      5'b00011: comb_result = {31'b0, operand_a_i < operand_b_i};
      5'b00100: comb_result = operand_a_i ^ operand_b_i;
      5'b00110: comb_result = operand_a_i | operand_b_i;
      5'b00111: comb_result = operand_a_i & operand_b_i;
`ifdef ALU_BARREL_SHIFT_EN
      5'b00001: comb_result = operand_a_i << shamt;
      5'b00101: comb_result = operand_a_i >> shamt;
      5'b01101: comb_result = $unsigned($signed(operand_a_i) >>> shamt);
`else
      // Only reached with a zero shift amount; non-zero amounts use the iterative path.
      5'b00001, 5'b00101, 5'b01101: comb_result = operand_a_i;
`endif
      5'b10000: comb_taken = (operand_a_i == operand_b_i);
      5'b10001: comb_taken = (operand_a_i != operand_b_i);
      5'b10100: comb_taken = ($signed(operand_a_i) <  $signed(operand_b_i));
      5'b10101: comb_taken = ($signed(operand_a_i) >= $signed(operand_b_i));
      5'b10110: comb_taken = (operand_a_i <  operand_b_i);
      5'b10111: comb_taken = (operand_a_i >= operand_b_i);
      5'b11111: begin
        comb_result = pc_i + 32'd4;
        comb_taken  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset clears everything, so an operation in flight is simply dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      result_q <= '0;
      taken_q  <= 1'b0;
      valid_q  <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      sh_q     <= '0;
      cnt_q    <= '0;
      right_q  <= 1'b0;
      arith_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i) begin
`ifndef ALU_BARREL_SHIFT_EN
            if (is_shift && (shamt != 5'd0)) begin
              state_q <= StShift;
              sh_q    <= operand_a_i;
              cnt_q   <= shamt;
              right_q <= alucontrol_i[2];
              arith_q <= alucontrol_i[3];
            end else
`endif
            begin
              state_q  <= StDone;
              valid_q  <= 1'b1;
              result_q <= comb_result;
              taken_q  <= comb_taken;
            end
          end
        end
        StShift: begin
`ifndef ALU_BARREL_SHIFT_EN
          sh_q  <= sh_step;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q  <= StDone;
            valid_q  <= 1'b1;
            result_q <= sh_step;
            taken_q  <= 1'b0;
          end
`else
          state_q <= StIdle;
`endif
        end
        StDone: begin
          // Return to idle on consume; no accept in this same cycle.
          if (ready_i) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            result_q <= '0;
            taken_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o        = (state_q == StIdle);
  assign valid_o        = valid_q;
  assign result_o       = result_q;
  assign branch_taken_o = taken_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, hand-written corner
// sequences (held result, reset mid-shift) and randomized ops against a reference model.
module tb_alu_exec;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit Barrel = 1'b1;
`else
  localparam bit Barrel = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [4:0]  alucontrol_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic [31:0] pc_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        branch_taken_o;

  alu_exec dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .alucontrol_i   (alucontrol_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .pc_i           (pc_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .result_o       (result_o),
    .branch_taken_o (branch_taken_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model written from the operation table with plain arithmetic.
  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] pc, output logic [31:0] r, output logic t);
    logic [31:0] p2, sa, sb;
    p2 = 32'd1 << b[4:0];
    sa = a ^ 32'h8000_0000;  // offset-binary: unsigned order equals signed order
    sb = b ^ 32'h8000_0000;
    r  = '0;
    t  = 1'b0;
    case (op)
      5'b00000: r = a + b;
      5'b01000: r = a + ~b + 32'd1;
      5'b00001: r = a * p2;
      5'b00010: r = (sa < sb) ? 32'd1 : 32'd0;
      5'b00011: r = (a < b) ? 32'd1 : 32'd0;
      5'b00100: r = a ^ b;
      5'b00101: r = a / p2;
      5'b01101: begin
        r = a / p2;
        if (a[31]) r = r | ~(32'hFFFF_FFFF / p2);
      end
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b10000: t = (a == b);
      5'b10001: t = (a != b);
      5'b10100: t = (sa < sb);
      5'b10101: t = (sa >= sb);
      5'b10110: t = (a < b);
      5'b10111: t = (a >= b);
      5'b11111: begin
        r = pc + 32'd4;
        t = 1'b1;
      end
      default: ;
    endcase
  endfunction

  function automatic int exp_latency(input logic [4:0] op, input logic [31:0] b);
    if (!Barrel && (op == 5'b00001 || op == 5'b00101 || op == 5'b01101)) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one op, scramble inputs after accept, measure latency, check result, consume.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] er,
                        input logic et, input int el);
    int cyc;
    bit leak;
    @(negedge clk_i);
    check({name, "_ready"}, {31'b0, ready_o}, 32'd1);
    ready_i = 1'b1;
    valid_i = 1'b1;
    alucontrol_i = op;
    operand_a_i = a;
    operand_b_i = b;
    pc_i = pc;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    alucontrol_i = 5'($urandom);
    operand_a_i = $urandom;
    operand_b_i = $urandom;
    pc_i = $urandom;
    cyc = 1;
    leak = 1'b0;
    forever begin
      @(negedge clk_i);
      if (valid_o) break;
      if (result_o != 0 || branch_taken_o) leak = 1'b1;
      if (cyc >= 64) break;
      @(posedge clk_i);
      cyc++;
    end
    check({name, "_latency"}, cyc, el);
    check({name, "_result"}, result_o, er);
    check({name, "_taken"}, {31'b0, branch_taken_o}, {31'b0, et});
    check({name, "_zero_while_busy"}, {31'b0, leak}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] res;
    logic        taken;
    int          lat;
  } vec_t;

  vec_t vecs[15];
  logic [4:0] pool[18];

  initial begin
    int cyc;
    bit rose;
    logic [31:0] er;
    logic et;
    logic [4:0] op;
    logic [31:0] a, b, pc;

    vecs[0]  = '{"add_ovf",   5'b00000, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h8000_0000, 1'b0, 1};
    vecs[1]  = '{"sra31",     5'b01101, 32'h8000_0000, 32'h3F, 32'h0, 32'hFFFF_FFFF, 1'b0,
                 Barrel ? 1 : 32};
    vecs[2]  = '{"blt",       5'b10100, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1};
    vecs[3]  = '{"bltu",      5'b10110, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1};
    vecs[4]  = '{"undef01001", 5'b01001, 32'h5, 32'h3, 32'h0, 32'h0, 1'b0, 1};
    vecs[5]  = '{"link_wrap", 5'b11111, 32'h1234, 32'h5678, 32'hFFFF_FFFC, 32'h0, 1'b1, 1};
    vecs[6]  = '{"sub_wrap",  5'b01000, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0, 1};
    vecs[7]  = '{"sll_zero",  5'b00001, 32'h1, 32'h20, 32'h0, 32'h1, 1'b0, 1};
    vecs[8]  = '{"srl4",      5'b00101, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0, 32'h0800_0000, 1'b0,
                 Barrel ? 1 : 5};
    vecs[9]  = '{"slt",       5'b00010, 32'h8000_0000, 32'h1, 32'h0, 32'h1, 1'b0, 1};
    vecs[10] = '{"sltu",      5'b00011, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 1'b0, 1};
    vecs[11] = '{"beq",       5'b10000, 32'h5, 32'h5, 32'h0, 32'h0, 1'b1, 1};
    vecs[12] = '{"bgeu",      5'b10111, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1};
    vecs[13] = '{"never",     5'b10010, 32'h7, 32'h7, 32'h0, 32'h0, 1'b0, 1};
    vecs[14] = '{"bge_eq",    5'b10101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1};

    pool = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01101,
             5'b00110, 5'b00111, 5'b10000, 5'b10001, 5'b10100, 5'b10101, 5'b10110, 5'b10111,
             5'b10010, 5'b11111};

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_taken", {31'b0, branch_taken_o}, 32'd0);
    rst_ni = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].res,
             vecs[i].taken, vecs[i].lat);

    // Link op held by backpressure, with an extra request that must be ignored.
    @(negedge clk_i);
    ready_i = 1'b0;
    valid_i = 1'b1;
    alucontrol_i = 5'b11111;
    operand_a_i = $urandom;
    operand_b_i = $urandom;
    pc_i = 32'h0000_1000;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    pc_i = $urandom;
    cyc = 1;
    forever begin
      @(negedge clk_i);
      if (valid_o || cyc >= 8) break;
      @(posedge clk_i);
      cyc++;
    end
    check("hold_latency", cyc, 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk_i);
      check("hold_result", result_o, 32'h0000_1004);
      check("hold_taken", {31'b0, branch_taken_o}, 32'd1);
      check("hold_valid", {31'b0, valid_o}, 32'd1);
      check("hold_ready", {31'b0, ready_o}, 32'd0);
      valid_i = 1'b1;
      alucontrol_i = 5'b00000;
      operand_a_i = 32'd1;
      operand_b_i = 32'd1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    check("hold_consumed_valid", {31'b0, valid_o}, 32'd0);
    check("hold_consumed_ready", {31'b0, ready_o}, 32'd1);
    rose = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      if (valid_o) rose = 1'b1;
    end
    check("hold_no_queued", {31'b0, rose}, 32'd0);

    // Reset in the middle of a long shift drops the operation.
    @(negedge clk_i);
    valid_i = 1'b1;
    alucontrol_i = 5'b00001;
    operand_a_i = 32'h0000_0F0F;
    operand_b_i = 32'd20;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    rose = 1'b0;
    repeat (9) begin
      @(posedge clk_i);
      #1;
      if (!Barrel && valid_o) rose = 1'b1;
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rstmid_ready", {31'b0, ready_o}, 32'd1);
    check("rstmid_valid", {31'b0, valid_o}, 32'd0);
    check("rstmid_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (30) begin
      @(negedge clk_i);
      if (valid_o) rose = 1'b1;
    end
    check("rstmid_never_valid", {31'b0, rose}, 32'd0);
    check("rstmid_ready_after", {31'b0, ready_o}, 32'd1);
    run_op("post_rst_add", 5'b00000, 32'd2, 32'd3, 32'd0, 32'd5, 1'b0, 1);

    // Randomized ops against the reference model.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom);
      else op = pool[$urandom_range(0, 17)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc = $urandom;
      ref_model(op, a, b, pc, er, et);
      run_op("rnd", op, a, b, pc, er, et, exp_latency(op, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have: clk_i  input  1  sole clock, rising edge.
REQ-002 The block SHALL have: rst_ni  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have: valid_i  input  1  request valid.
REQ-004 The block SHALL have: ready_o  output  1  block can accept a request.
REQ-005 The block SHALL have: alucontrol_i  input  5  operation code, encoding per REQ-012.
REQ-006 The block SHALL have: operand_a_i, operand_b_i  input  32 each  source operands.
REQ-007 The block SHALL have: pc_i  input  32  program counter of the instruction.
REQ-008 The block SHALL have: valid_o  output  1  result valid.
REQ-009 The block SHALL have: ready_i  input  1  consumer accepts the result.
REQ-010 The block SHALL have: result_o  output  32  result; branch_taken_o  output  1  redirect flag.

Function
REQ-011 Handshakes: request accepted on a rising edge with valid_i && ready_o; result consumed on a rising edge with valid_o && ready_i.
REQ-012 Code map:
- 00000 add; 01000 sub; 00001 sll; 00010 slt (signed); 00011 sltu; 00100 xor; 00101 srl; 01101 sra; 00110 or; 00111 and.
- Branch codes set result_o=0 and branch_taken_o as follows: 10000 beq; 10001 bne; 10100 blt; 10101 bge; 10110 bltu; 10111 bgeu; 10010/10011 never taken.
- 11111: result_o=pc_i+4, branch_taken_o=1.
- Any other code: result_o=0, branch_taken_o=0.
REQ-013 Arithmetic: add/sub/pc+4 SHALL be modulo 2^32 with no overflow flag; 0x7FFFFFFF+1 = 0x80000000; 0xFFFFFFFC+4 = 0.
REQ-014 Shift amount SHALL be operand_b_i[4:0]; operand_b_i[31:5] ignored; sra fills with operand_a_i[31].
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE; ready_o SHALL be 1 only in IDLE.
REQ-016 Transitions:
- IDLE -> DONE on accept of a non-shift op, or of a shift with shamt=0.
- IDLE -> SHIFT on accept of a shift with shamt>0.
- SHIFT -> DONE when the remaining count reaches 0.
- DONE -> IDLE on result consumed.
REQ-017 Non-shift latency: valid_o SHALL rise exactly 1 cycle after accept.
REQ-018 Iterative shift (macro undefined): 1 bit per cycle; valid_o SHALL rise shamt+1 cycles after accept, shamt=0 giving 1 cycle.
REQ-019 Operands and code SHALL be captured at accept; input changes after accept SHALL have no effect on the pending result.
REQ-020 In DONE with ready_i=0, result_o, branch_taken_o and valid_o SHALL hold stable.
REQ-021 valid_o=1 only in DONE; result_o and branch_taken_o SHALL be 0 whenever valid_o=0.
REQ-022 No new request SHALL be accepted in the cycle a result is consumed; back-to-back throughput is 1 op per 2 cycles minimum.
REQ-023 valid_i asserted in SHIFT or DONE SHALL be ignored and not queued.

Reset
REQ-024 While rst_ni=0: state=IDLE, ready_o=1, valid_o=0, result_o=0, branch_taken_o=0, shift counter=0.
REQ-025 Reset asserted mid-SHIFT or mid-DONE SHALL discard the operation with no result produced; after rst_ni rises, the first accept SHALL behave as from a fresh IDLE.

Configuration
REQ-026 Macro ALU_BARREL_SHIFT_EN:
- Defined: shifts SHALL be computed combinationally and behave as non-shift ops (IDLE -> DONE, latency 1); SHIFT state unreachable.
- Undefined: iterative shifter per REQ-018; results SHALL be bit-identical in both builds.

Verification
REQ-027 The bench SHALL cover: code 00000, a=0x7FFFFFFF, b=1 -> result_o=0x80000000, branch_taken_o=0, valid_o 1 cycle after accept.
REQ-028 The bench SHALL cover: code 01101, a=0x80000000, b=0x0000003F (shamt 31) -> result_o=0xFFFFFFFF; valid_o 32 cycles after accept (macro undefined) or 1 cycle (defined).
REQ-029 The bench SHALL cover: code 10100, a=0xFFFFFFFF, b=1 -> branch_taken_o=1; code 10110 with same operands -> branch_taken_o=0; result_o=0 in both.
REQ-030 The bench SHALL cover: code 11111, pc_i=0x00001000 with ready_i held 0 for 5 cycles -> result_o=0x00001004 and branch_taken_o=1 stable all 5 cycles, ready_o=0, an extra valid_i ignored.
REQ-031 The bench SHALL cover: sll with shamt=20 and rst_ni pulsed low at cycle 10 -> valid_o never rises for that op, ready_o=1 after reset, next add completes in 1 cycle.
REQ-032 The bench SHALL cover: code 01001, a=5, b=3 -> result_o=0, branch_taken_o=0, valid_o after 1 cycle.
